// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package alu_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MULS = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIVS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Divide by zero reports a quotient of this bit replicated across the word.
    localparam logic DZ_QUOT_BIT = 1'b1;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the core and the multiply/divide unit.
interface alu_muldiv_if #(
    parameter int dw = 16
);
    logic          start;
    logic [1:0]    op;
    logic [dw-1:0] AI;
    logic [dw-1:0] BI;
    logic          busy;
    logic          done;
    logic [dw-1:0] OUT;
    logic [dw-1:0] OUTHI;
    logic          Z;
    logic          N;
    logic          V;
    logic          DZ;

    modport master (
        output start, op, AI, BI,
        input  busy, done, OUT, OUTHI, Z, N, V, DZ
    );

    modport slave (
        input  start, op, AI, BI,
        output busy, done, OUT, OUTHI, Z, N, V, DZ
    );
endinterface

// File: rtl/alu_muldiv_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) iteration.
module muldiv_step #(
    parameter int dw = 16
) (
    input  logic [dw-1:0] acc_i,
    input  logic [dw-1:0] q_i,
    input  logic [dw-1:0] b_i,
    input  logic          div_i,
    output logic [dw-1:0] acc_o,
    output logic          bit_o
);
    logic [dw:0] sum_s;
    logic [dw:0] shl_s;
    logic [dw:0] diff_s;

    // Multiply: bit_o is shifted into the top of q. Divide: bit_o is the quotient bit.
    always_comb begin
        sum_s  = q_i[0] ? ({1'b0, acc_i} + {1'b0, b_i}) : {1'b0, acc_i};
        shl_s  = {acc_i, q_i[dw-1]};
        diff_s = shl_s - {1'b0, b_i};
        if (div_i) begin
            bit_o = ~diff_s[dw];
            acc_o = diff_s[dw] ? shl_s[dw-1:0] : diff_s[dw-1:0];
        end else begin
            bit_o = sum_s[0];
            acc_o = sum_s[dw:1];
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit: FSM, iteration counter, sign handling and result registers.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int dw    = 16,
    parameter int logdw = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RDY,
    alu_muldiv_if.slave bus
);
    localparam logic [dw-1:0] MOST_NEG = {1'b1, {(dw-1){1'b0}}};
    localparam logic [dw-1:0] ALL_ONES = {dw{1'b1}};
    localparam logic [dw-1:0] ZERO     = {dw{1'b0}};

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [logdw-1:0]  cnt_q, cnt_d;
    logic [dw-1:0]     acc_q, acc_d, q_q, q_d, b_q, b_d;
    logic              qsign_q, qsign_d, rsign_q, rsign_d;
    logic              ovf_q, ovf_d, dzp_q, dzp_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [dw-1:0]     out_q, out_d, outhi_q, outhi_d;
    logic              z_q, z_d, n_q, n_d, v_q, v_d, dz_q, dz_d;

    op_e               op_in;
    logic [dw-1:0]     ai_mag, bi_mag, step_acc, quot_fix, rem_fix;
    logic              step_bit;
    logic [2*dw-1:0]   prod_raw, prod_fix;

    assign op_in = op_e'(bus.op);

    muldiv_step #(.dw(dw)) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .b_i   (b_q),
        .div_i (op_is_div(op_q)),
        .acc_o (step_acc),
        .bit_o (step_bit)
    );

    // Operand magnitudes at accept and sign-corrected results at fix-up.
    always_comb begin
        ai_mag   = (op_is_signed(op_in) && bus.AI[dw-1]) ? -bus.AI : bus.AI;
        bi_mag   = (op_is_signed(op_in) && bus.BI[dw-1]) ? -bus.BI : bus.BI;
        prod_raw = {acc_q, q_q};
        prod_fix = qsign_q ? -prod_raw : prod_raw;
        quot_fix = qsign_q ? -q_q : q_q;
        rem_fix  = rsign_q ? -acc_q : acc_q;
    end

    // Next-state and result computation.
    always_comb begin
        state_d = state_q;  op_d    = op_q;    cnt_d   = cnt_q;
        acc_d   = acc_q;    q_d     = q_q;     b_d     = b_q;
        qsign_d = qsign_q;  rsign_d = rsign_q; ovf_d   = ovf_q;  dzp_d = dzp_q;
        busy_d  = busy_q;   done_d  = 1'b0;
        out_d   = out_q;    outhi_d = outhi_q;
        z_d     = z_q;      n_d     = n_q;     v_d     = v_q;    dz_d  = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = op_in;
                    q_d     = ai_mag;
                    b_d     = bi_mag;
                    qsign_d = op_is_signed(op_in) & (bus.AI[dw-1] ^ bus.BI[dw-1]);
                    rsign_d = op_is_signed(op_in) & bus.AI[dw-1];
                    ovf_d   = (op_in == OP_DIVS) && (bus.AI == MOST_NEG) && (bus.BI == ALL_ONES);
                    cnt_d   = {logdw{1'b0}};
                    busy_d  = 1'b1;
                    if (op_is_div(op_in) && (bus.BI == ZERO)) begin
                        // Raw dividend parked in the accumulator for OUTHI.
                        acc_d   = bus.AI;
                        dzp_d   = 1'b1;
                        state_d = ST_FIX;
                    end else begin
                        acc_d   = ZERO;
                        dzp_d   = 1'b0;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                q_d   = op_is_div(op_q) ? {q_q[dw-2:0], step_bit} : {step_bit, q_q[dw-1:1]};
                cnt_d = cnt_q + logdw'(1);
                if (cnt_q == logdw'(dw - 1)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dzp_q) begin
                    out_d   = {dw{DZ_QUOT_BIT}};
                    outhi_d = acc_q;
                    z_d     = ({dw{DZ_QUOT_BIT}} == ZERO);
                    n_d     = DZ_QUOT_BIT;
                    v_d     = 1'b0;
                    dz_d    = 1'b1;
                end else if (op_is_div(op_q)) begin
                    out_d   = quot_fix;
                    outhi_d = rem_fix;
                    z_d     = (quot_fix == ZERO);
                    n_d     = quot_fix[dw-1];
                    v_d     = ovf_q;
                    dz_d    = 1'b0;
                end else begin
                    out_d   = prod_fix[dw-1:0];
                    outhi_d = prod_fix[2*dw-1:dw];
                    z_d     = (prod_fix == {(2*dw){1'b0}});
                    n_d     = prod_fix[2*dw-1];
                    if (op_q == OP_MULS) begin
                        v_d = (prod_fix[2*dw-1:dw] != {dw{prod_fix[dw-1]}});
                    end else begin
                        v_d = (prod_fix[2*dw-1:dw] != ZERO);
                    end
                    dz_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset wins over the RDY stall, RDY=0 freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;  op_q    <= OP_MULU;  cnt_q   <= {logdw{1'b0}};
            acc_q   <= ZERO;     q_q     <= ZERO;     b_q     <= ZERO;
            qsign_q <= 1'b0;     rsign_q <= 1'b0;     ovf_q   <= 1'b0;  dzp_q <= 1'b0;
            busy_q  <= 1'b0;     done_q  <= 1'b0;
            out_q   <= ZERO;     outhi_q <= ZERO;
            z_q     <= 1'b0;     n_q     <= 1'b0;     v_q     <= 1'b0;  dz_q  <= 1'b0;
        end else if (RDY) begin
            state_q <= state_d;  op_q    <= op_d;     cnt_q   <= cnt_d;
            acc_q   <= acc_d;    q_q     <= q_d;      b_q     <= b_d;
            qsign_q <= qsign_d;  rsign_q <= rsign_d;  ovf_q   <= ovf_d; dzp_q <= dzp_d;
            busy_q  <= busy_d;   done_q  <= done_d;
            out_q   <= out_d;    outhi_q <= outhi_d;
            z_q     <= z_d;      n_q     <= n_d;      v_q     <= v_d;   dz_q  <= dz_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.OUT   = out_q;
    assign bus.OUTHI = outhi_q;
    assign bus.Z     = z_q;
    assign bus.N     = n_q;
    assign bus.V     = v_q;
    assign bus.DZ    = dz_q;
endmodule
